// File: rtl/seq_detect_pkg.sv
// Shared defaults and helpers for the programmable serial pattern detector.
package seq_detect_pkg;

    localparam int MASK_W = 32;

    localparam logic [7:0] DEF_PATTERN = 8'b0000_1101;
    localparam int         DEF_LEN     = 4;
    localparam logic       DEF_OVERLAP = 1'b1;

    // Low-len-bit compare mask; patterns wider than MASK_W are not supported.
    function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (i < len) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] base;

    always_comb begin
        base  = clr ? '0 : cnt_q;
        cnt_d = base;
        if (inc && (base != '1)) begin
            cnt_d = base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with Mealy match pulse,
// registered copy and saturating match counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               y,
    output logic               y_reg,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               y_q;

    logic [MAX_LEN-1:0] window;
    logic [MASK_W-1:0]  mask;
    logic [MASK_W-1:0]  diff;
    logic               cfg_ok;
    logic               sample;
    logic               armed;
    logic               hit;

    assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign sample = din_valid && !cfg_we;

    // Newest bit sits at index 0, matching the pattern bit order.
    assign window = {hist_q, din};
    assign mask   = len_mask(32'(len_q));
    assign diff   = MASK_W'(window ^ pat_q);
    assign armed  = fill_q >= (len_q - LEN_W'(1));
    assign hit    = sample && armed && ((diff & mask) == '0);
    assign y      = hit && !rst;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (cfg_we) begin
            if (cfg_ok) begin
                hist_d = '0;
                fill_d = '0;
            end
        end else if (din_valid) begin
            hist_d = window[MAX_LEN-2:0];
            if (hit && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != LEN_W'(MAX_LEN)) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= MAX_LEN'(DEF_PATTERN);
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= DEF_OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
        end else begin
            if (cfg_we && cfg_ok) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                ovl_q <= cfg_overlap;
            end
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y;
        end
    end

    assign y_reg = y_q;

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .inc(y),
        .cnt(match_cnt)
    );

endmodule
